// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Brief    : Main control FSM of the multi-cycle RV32I core with a shared
//            instruction/data memory port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multicycle_controller (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] op_code_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       addr_src_o,
  output logic       ir_wr_o,
  output logic       pc_wr_o,
  output logic       reg_wr_en_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] result_src_o,
  output logic       branch_o,
  output logic       retire_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_TRAP      = 4'd11
  } state_e;

  state_e state_q, state_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (mem_ready_i) state_d = S_DECODE;
      S_DECODE: begin
        case (op_code_i)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_TRAP;
        endcase
      end
      // Opcode changing between DECODE and here is treated as illegal.
      S_MEM_ADDR: begin
        if (op_code_i == OP_LOAD)       state_d = S_MEM_READ;
        else if (op_code_i == OP_STORE) state_d = S_MEM_WRITE;
        else                            state_d = S_TRAP;
      end
      S_MEM_READ:  if (mem_ready_i) state_d = S_MEM_WB;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready_i) state_d = S_FETCH;
      S_EXEC_R:    state_d = S_ALU_WB;
      S_EXEC_I:    state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JAL:       state_d = S_ALU_WB;
      S_TRAP:      state_d = S_TRAP;
      default:     state_d = S_TRAP;
    endcase
  end

  // Outputs decode the state register; reset masks everything to zero.
  always_comb begin
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    addr_src_o   = 1'b0;
    ir_wr_o      = 1'b0;
    pc_wr_o      = 1'b0;
    reg_wr_en_o  = 1'b0;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 2'b00;
    result_src_o = 2'b00;
    branch_o     = 1'b0;
    retire_o     = 1'b0;
    illegal_o    = 1'b0;
    state_o      = 4'd0;
    if (!rst_i) begin
      state_o = state_q;
      case (state_q)
        S_FETCH: begin
          mem_req_o    = 1'b1;
          alu_src_b_o  = 2'b10;
          result_src_o = 2'b10;
          ir_wr_o      = mem_ready_i;
          pc_wr_o      = mem_ready_i;
        end
        S_DECODE: begin
          alu_src_a_o = 2'b01;
          alu_src_b_o = 2'b01;
        end
        S_MEM_ADDR: begin
          alu_src_a_o = 2'b10;
          alu_src_b_o = 2'b01;
        end
        S_MEM_READ: begin
          mem_req_o  = 1'b1;
          addr_src_o = 1'b1;
        end
        S_MEM_WB: begin
          result_src_o = 2'b01;
          reg_wr_en_o  = 1'b1;
          retire_o     = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_req_o  = 1'b1;
          mem_we_o   = 1'b1;
          addr_src_o = 1'b1;
          retire_o   = mem_ready_i;
        end
        S_EXEC_R: begin
          alu_src_a_o = 2'b10;
          alu_op_o    = 2'b10;
        end
        S_EXEC_I: begin
          alu_src_a_o = 2'b10;
          alu_src_b_o = 2'b01;
          alu_op_o    = 2'b10;
        end
        S_ALU_WB: begin
          reg_wr_en_o = 1'b1;
          retire_o    = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_o = 2'b10;
          alu_op_o    = 2'b01;
          branch_o    = 1'b1;
          retire_o    = 1'b1;
          pc_wr_o     = zero_i;
        end
        S_JAL: begin
          alu_src_a_o = 2'b01;
          alu_src_b_o = 2'b10;
          pc_wr_o     = 1'b1;
        end
        S_TRAP:  illegal_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// Module   : tb_multicycle_controller
// Brief    : Randomized instruction-level bench for multicycle_controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

  localparam logic [6:0] C_LOAD   = 7'b0000011;
  localparam logic [6:0] C_STORE  = 7'b0100011;
  localparam logic [6:0] C_RTYPE  = 7'b0110011;
  localparam logic [6:0] C_ITYPE  = 7'b0010011;
  localparam logic [6:0] C_BRANCH = 7'b1100011;
  localparam logic [6:0] C_JAL    = 7'b1101111;
  localparam logic [6:0] C_ECALL  = 7'b1110011;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op_code;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, addr_src, ir_wr, pc_wr, reg_wr_en;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic       branch, retire, illegal;
  logic [3:0] state;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_controller dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .op_code_i   (op_code),
    .zero_i      (zero),
    .mem_ready_i (mem_ready),
    .mem_req_o   (mem_req),
    .mem_we_o    (mem_we),
    .addr_src_o  (addr_src),
    .ir_wr_o     (ir_wr),
    .pc_wr_o     (pc_wr),
    .reg_wr_en_o (reg_wr_en),
    .alu_src_a_o (alu_src_a),
    .alu_src_b_o (alu_src_b),
    .alu_op_o    (alu_op),
    .result_src_o(result_src),
    .branch_o    (branch),
    .retire_o    (retire),
    .illegal_o   (illegal),
    .state_o     (state)
  );

  always #5 clk = ~clk;

  wire [16:0] w_ctl = {mem_req, mem_we, addr_src, ir_wr, pc_wr, reg_wr_en,
                       alu_src_a, alu_src_b, alu_op, result_src,
                       branch, retire, illegal};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Entered and left at posedge+1; leaves the DUT in its first FETCH cycle.
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin
      mem_ready = 1'($urandom);
      zero      = 1'($urandom);
      op_code   = 7'($urandom);
      @(negedge clk);
      check_eq("rst_ctl", 32'(w_ctl), 32'h0);
      check_eq("rst_state", 32'(state), 32'h0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
  endtask

  // zmode: 0 = zero_i low, 1 = zero_i high, otherwise random.
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input int zmode);
    int  exp_st[$];
    bit  is_ld, is_st, is_br, is_jal, wr_rd;
    int  n_cyc, mem_lo, mem_hi;
    logic z_now;
    is_ld  = (op == C_LOAD);
    is_st  = (op == C_STORE);
    is_br  = (op == C_BRANCH);
    is_jal = (op == C_JAL);
    wr_rd  = !(is_st || is_br);
    for (int i = 0; i <= fw; i++) exp_st.push_back(0);
    exp_st.push_back(1);
    if (is_ld || is_st) begin
      exp_st.push_back(2);
      for (int i = 0; i <= mw; i++) exp_st.push_back(is_ld ? 3 : 5);
      if (is_ld) exp_st.push_back(4);
    end else if (is_br) exp_st.push_back(9);
    else if (is_jal) begin exp_st.push_back(10); exp_st.push_back(8); end
    else begin exp_st.push_back(op == C_RTYPE ? 6 : 7); exp_st.push_back(8); end
    n_cyc  = exp_st.size();
    mem_lo = (is_ld || is_st) ? fw + 3 : -1;
    mem_hi = (is_ld || is_st) ? fw + 3 + mw : -2;

    for (int c = 0; c < n_cyc; c++) begin
      bit in_f, in_m;
      logic [2:0] exp_mem;
      logic exp_pc;
      in_f = (c <= fw);
      in_m = (c >= mem_lo) && (c <= mem_hi);
      if (in_f)      mem_ready = (c == fw);
      else if (in_m) mem_ready = (c == mem_hi);
      else           mem_ready = 1'($urandom);
      op_code = in_f ? 7'($urandom) : op;
      z_now   = (zmode == 0) ? 1'b0 : (zmode == 1) ? 1'b1 : 1'($urandom);
      zero    = z_now;
      @(negedge clk);
      exp_mem = {in_f || in_m, in_m && is_st, in_m};
      exp_pc  = (c == fw) || (is_jal && c == fw + 2) || (is_br && c == fw + 2 && z_now);
      check_eq($sformatf("state op%b c%0d", op, c), 32'(state), 32'(exp_st[c]));
      check_eq($sformatf("mem_if op%b c%0d", op, c), 32'({mem_req, mem_we, addr_src}), 32'(exp_mem));
      check_eq($sformatf("ir_wr op%b c%0d", op, c), 32'(ir_wr), 32'(c == fw));
      check_eq($sformatf("pc_wr op%b c%0d", op, c), 32'(pc_wr), 32'(exp_pc));
      check_eq($sformatf("retire op%b c%0d", op, c), 32'(retire), 32'(c == n_cyc - 1));
      check_eq($sformatf("reg_wr op%b c%0d", op, c), 32'(reg_wr_en), 32'(wr_rd && c == n_cyc - 1));
      check_eq($sformatf("branch op%b c%0d", op, c), 32'(branch), 32'(is_br && c == n_cyc - 1));
      if (in_f)
        check_eq("fetch_mux", 32'({alu_src_a, alu_src_b, alu_op, result_src}), 32'(8'b00_10_00_10));
      if (c == n_cyc - 1 && wr_rd)
        check_eq("wb_result_src", 32'(result_src), is_ld ? 32'd1 : 32'd0);
      if (c == n_cyc - 1 && is_br)
        check_eq("br_alu_op", 32'(alu_op), 32'd1);
      @(posedge clk); #1;
    end
  endtask

  logic [6:0] legal_ops [6];

  initial begin
    legal_ops[0] = C_LOAD;  legal_ops[1] = C_STORE;  legal_ops[2] = C_RTYPE;
    legal_ops[3] = C_ITYPE; legal_ops[4] = C_BRANCH; legal_ops[5] = C_JAL;
    rst = 1'b1; op_code = '0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    run_instr(C_ITYPE,  0, 0, 2);
    run_instr(C_LOAD,   2, 1, 2);
    run_instr(C_STORE,  0, 3, 2);
    run_instr(C_BRANCH, 0, 0, 1);
    run_instr(C_BRANCH, 1, 0, 0);
    run_instr(C_JAL,    0, 0, 2);
    run_instr(C_RTYPE,  0, 0, 2);

    for (int n = 0; n < 200; n++)
      run_instr(legal_ops[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3), 2);

    // Illegal opcode: TRAP is sticky and silent.
    mem_ready = 1'b1; op_code = 7'($urandom);
    @(negedge clk);
    check_eq("trap_fetch", 32'(state), 32'd0);
    @(posedge clk); #1;
    op_code = C_ECALL;
    @(negedge clk);
    check_eq("trap_decode", 32'(state), 32'd1);
    @(posedge clk); #1;
    for (int c = 0; c < 20; c++) begin
      mem_ready = 1'($urandom); zero = 1'($urandom); op_code = 7'($urandom);
      @(negedge clk);
      check_eq($sformatf("trap_state c%0d", c), 32'(state), 32'd11);
      check_eq($sformatf("trap_ctl c%0d", c), 32'(w_ctl), 32'h1);
      @(posedge clk); #1;
    end
    do_reset();

    // Reset while a load's memory read is pending.
    mem_ready = 1'b1; op_code = 7'($urandom);
    @(posedge clk); #1;
    op_code = C_LOAD;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    check_eq("pend_state", 32'(state), 32'd3);
    check_eq("pend_req", 32'({mem_req, addr_src}), 32'b11);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_ctl", 32'(w_ctl), 32'h0);
    check_eq("midrst_state", 32'(state), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_instr(C_LOAD, 1, 2, 2);
    run_instr(legal_ops[$urandom_range(0, 5)], 0, 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
